// File: rtl/core_pkg.sv
// Shared definitions for the RV64 pipeline stage-register bank:
// bubble instruction, reset PC, result-select encodings and the
// instruction field positions used to pull register addresses.
package core_pkg;

    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;   // addi x0,x0,0
    localparam logic [63:0] RESET_PC_C  = 64'h0;

    // Result select driven by the decoder; bit0 marks a load.
    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_e;

    localparam int REG_W   = 5;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    // Fields carried through ID/EX.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_write;
        logic             jump;
        logic             branch;
        logic [1:0]       result_src;
    } ex_fields_t;

    // Fields carried through EX/MEM and MEM/WB.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic [1:0]       result_src;
    } wb_fields_t;

    function automatic logic [REG_W-1:0] rs1_of(input logic [31:0] instr);
        return instr[RS1_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] rs2_of(input logic [31:0] instr);
        return instr[RS2_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] rd_of(input logic [31:0] instr);
        return instr[RD_LSB +: REG_W];
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register. Priority: reset > clear (bubble) >
// hold (enable low) > load. Clear uses the same value as reset so a
// flushed stage looks exactly like a freshly reset one.
module pipe_stage_reg #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q;

    // Stage contents: reset, then bubble on clear, then hold or capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= RST_VAL;
        end else if (clr_i) begin
            stage_q <= RST_VAL;
        end else if (en_i) begin
            stage_q <= d_i;
        end else begin
            stage_q <= stage_q;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/pipe_ctrl_regs.sv
// Stage-register bank between the five RV64 pipeline stages. Carries
// PC/instruction into decode and register addresses/controls through
// EX, MEM and WB, and keeps stall/flush/retire bring-up counters.
module pipe_ctrl_regs
    import core_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_C),
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_C,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic [XLEN-1:0]  PCNextF,
    input  logic [31:0]      InstrF,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic [1:0]       ResultSrcD,
    output logic [XLEN-1:0]  PCF,
    output logic [31:0]      InstrD,
    output logic [XLEN-1:0]  PCD,
    output logic [4:0]       A1,
    output logic [4:0]       A2,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic [1:0]       ResultSrcE,
    output logic [4:0]       RdM,
    output logic             RegWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [4:0]       RdW,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] RetireCnt
);

    localparam int DW = 1 + XLEN + 32;

    logic       valid_d_s;
    ex_fields_t ex_d, ex_q;
    wb_fields_t mem_d, mem_q, wb_q;

    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
    logic [CNT_W-1:0] retire_cnt_d, retire_cnt_q;

    // Fetch PC
    pipe_stage_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc (
        .clk_i (clk), .rst_i (rst), .en_i (~StallF), .clr_i (1'b0),
        .d_i   (PCNextF), .q_o (PCF)
    );

    // IF/ID: {valid, pc, instr}; a flushed entry becomes a NOP bubble
    pipe_stage_reg #(.W(DW), .RST_VAL({1'b0, {XLEN{1'b0}}, NOP_INSTR})) u_ifid (
        .clk_i (clk), .rst_i (rst), .en_i (~StallD), .clr_i (FlushD),
        .d_i   ({1'b1, PCF, InstrF}), .q_o ({valid_d_s, PCD, InstrD})
    );

    assign A1 = rs1_of(InstrD);
    assign A2 = rs2_of(InstrD);

    // ID/EX next value; an invalid decode slot enters EX as an all-zero
    // bubble so it can never match a forwarding or load-use compare
    always_comb begin
        ex_d = '0;
        if (valid_d_s) begin
            ex_d.valid      = 1'b1;
            ex_d.rs1        = A1;
            ex_d.rs2        = A2;
            ex_d.rd         = rd_of(InstrD);
            ex_d.reg_write  = RegWriteD;
            ex_d.mem_write  = MemWriteD;
            ex_d.jump       = JumpD;
            ex_d.branch     = BranchD;
            ex_d.result_src = ResultSrcD;
        end else begin
            ex_d = '0;
        end
    end

    pipe_stage_reg #(.W($bits(ex_fields_t))) u_idex (
        .clk_i (clk), .rst_i (rst), .en_i (1'b1), .clr_i (FlushE),
        .d_i   (ex_d), .q_o (ex_q)
    );

    assign mem_d = '{valid: ex_q.valid, rd: ex_q.rd,
                     reg_write: ex_q.reg_write, result_src: ex_q.result_src};

    pipe_stage_reg #(.W($bits(wb_fields_t))) u_exmem (
        .clk_i (clk), .rst_i (rst), .en_i (1'b1), .clr_i (1'b0),
        .d_i   (mem_d), .q_o (mem_q)
    );

    pipe_stage_reg #(.W($bits(wb_fields_t))) u_memwb (
        .clk_i (clk), .rst_i (rst), .en_i (1'b1), .clr_i (1'b0),
        .d_i   (mem_q), .q_o (wb_q)
    );

    assign Rs1E       = ex_q.rs1;
    assign Rs2E       = ex_q.rs2;
    assign RdE        = ex_q.rd;
    assign RegWriteE  = ex_q.reg_write;
    assign MemWriteE  = ex_q.mem_write;
    assign JumpE      = ex_q.jump;
    assign BranchE    = ex_q.branch;
    assign ResultSrcE = ex_q.result_src;
    assign RdM        = mem_q.rd;
    assign RegWriteM  = mem_q.reg_write;
    assign ResultSrcM = mem_q.result_src;
    assign RdW        = wb_q.rd;
    assign RegWriteW  = wb_q.reg_write;
    assign ResultSrcW = wb_q.result_src;

    // Counter increments; all wrap naturally at 2^CNT_W
    always_comb begin
        stall_cnt_d  = stall_cnt_q  + CNT_W'(StallF);
        flush_cnt_d  = flush_cnt_q  + CNT_W'(FlushD);
        retire_cnt_d = retire_cnt_q + CNT_W'(wb_q.valid);
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= {CNT_W{1'b0}};
            flush_cnt_q  <= {CNT_W{1'b0}};
            retire_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign StallCnt  = stall_cnt_q;
    assign FlushCnt  = flush_cnt_q;
    assign RetireCnt = retire_cnt_q;

endmodule
